// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the zero-sequence detector: loads a word on
// load/ready, shifts it out one bit per clock, optionally appends parity.
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int PARITY    = 0,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam bit PAR_EN = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PAR,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = PAR_EN ? PAR : DONE;
            PAR:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        if (state_q == IDLE && load) begin
            shift_d = data_in;
            cnt_d   = '0;
            par_d   = PAR_ODD ? ~^data_in : ^data_in;
        end else if (state_q == SHIFT) begin
            // Shift toward whichever end drives x_out.
            shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_comb begin
        ready   = 1'b0;
        x_valid = 1'b0;
        done    = 1'b0;
        x_out   = IDLE_BIT;
        case (state_q)
            IDLE:  ready = 1'b1;
            SHIFT: begin
                x_valid = 1'b1;
                x_out   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
            end
            PAR: begin
                x_valid = 1'b1;
                x_out   = par_q;
            end
            DONE:    done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign busy = ~ready;

endmodule
